// File: rtl/yolo_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// yolo_axi_rd_arbiter
//   Shares the single AXI master read port (AR/R) of yolo_engine between three
//   DRAM loaders (0: IFM, 1: filter, 2: bias/scale). Requesters are granted in
//   round-robin order. Each grant issues one INCR burst, and only one burst is
//   outstanding at a time. R beats are steered to the granted loader only, and
//   the grant is held until the RLAST beat completes.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester burst request / one-hot accept (comb)
//   req_addr, req_len    per-requester byte address and AXI length (beats-1)
//   rd_data              M_RDATA broadcast to all requesters (comb)
//   rd_valid, rd_last    one-hot beat valid and qualified RLAST (comb)
//   rd_ready             per-requester beat ready
//   M_AR*                AXI read address channel (registered)
//   M_R*                 AXI read data channel; M_RREADY comb from rd_ready
//   busy                 FSM is not IDLE
//   grant_id             current or last granted requester
//   err                  sticky protocol/response error, cleared only by rstn
// -----------------------------------------------------------------------------
module yolo_axi_rd_arbiter #(
    parameter int unsigned AXI_WIDTH_AD = 32,
    parameter int unsigned AXI_WIDTH_DA = 32,
    parameter int unsigned AXI_WIDTH_ID = 4,
    parameter int unsigned N_REQ        = 3
) (
    input  logic                            clk,
    input  logic                            rstn,

    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ*AXI_WIDTH_AD-1:0]   req_addr,
    input  logic [N_REQ*8-1:0]              req_len,

    output logic [AXI_WIDTH_DA-1:0]         rd_data,
    output logic [N_REQ-1:0]                rd_valid,
    output logic                            rd_last,
    input  logic [N_REQ-1:0]                rd_ready,

    output logic                            M_ARVALID,
    input  logic                            M_ARREADY,
    output logic [AXI_WIDTH_AD-1:0]         M_ARADDR,
    output logic [AXI_WIDTH_ID-1:0]         M_ARID,
    output logic [7:0]                      M_ARLEN,
    output logic [2:0]                      M_ARSIZE,
    output logic [1:0]                      M_ARBURST,

    input  logic                            M_RVALID,
    output logic                            M_RREADY,
    input  logic [AXI_WIDTH_DA-1:0]         M_RDATA,
    input  logic                            M_RLAST,
    input  logic [AXI_WIDTH_ID-1:0]         M_RID,
    input  logic [1:0]                      M_RRESP,

    output logic                            busy,
    output logic [1:0]                      grant_id,
    output logic                            err
);

    localparam int unsigned GNT_W = 2;
    localparam int unsigned LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [GNT_W-1:0]        last_grant_q, last_grant_d;
    logic [GNT_W-1:0]        grant_q, grant_d;
    logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [AXI_WIDTH_ID-1:0] id_q, id_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    // Low for the first cycle after reset release so no grant is offered then.
    logic                    active_q;

    logic                    win_found;
    logic [GNT_W-1:0]        win_idx;

    // Cyclic position k steps after the last granted requester.
    function automatic logic [GNT_W-1:0] rr_idx(input logic [GNT_W-1:0] last,
                                                input int unsigned      k);
        int unsigned s;
        s = (32'(last) + k) % N_REQ;
        return GNT_W'(s);
    endfunction

    // Round-robin search: first valid requester starting at last_grant+1, so
    // the requester just served is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            if (!win_found && req_valid[rr_idx(last_grant_q, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_idx(last_grant_q, k);
            end
        end
    end

    // Next-state and channel steering.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        req_ready    = '0;
        rd_valid     = '0;
        M_RREADY     = 1'b0;
        rd_last      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (active_q && win_found) begin
                    req_ready[win_idx] = 1'b1;
                    grant_d = win_idx;
                    addr_d  = req_addr[32'(win_idx)*AXI_WIDTH_AD +: AXI_WIDTH_AD];
                    len_d   = req_len[32'(win_idx)*LEN_W +: LEN_W];
                    id_d    = AXI_WIDTH_ID'(win_idx);
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end

            ADDR: begin
                if (M_ARREADY) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                rd_valid[grant_q] = M_RVALID;
                M_RREADY          = rd_ready[grant_q];
                rd_last           = M_RLAST;
                if (M_RVALID && rd_ready[grant_q]) begin
                    cnt_d = cnt_q + 8'd1;
                    // Errors are only flagged; the beat is still delivered.
                    if (M_RRESP != 2'b00)              err_d = 1'b1;
                    if (M_RID != id_q)                 err_d = 1'b1;
                    if (M_RLAST && (cnt_q != len_q))   err_d = 1'b1;
                    if (!M_RLAST && (cnt_q == len_q))  err_d = 1'b1;
                    if (M_RLAST) begin
                        last_grant_d = grant_q;
                        cnt_d        = '0;
                        state_d      = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched burst fields.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_W'(N_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            active_q     <= 1'b1;
        end
    end

    assign M_ARVALID = (state_q == ADDR);
    assign M_ARADDR  = addr_q;
    assign M_ARID    = id_q;
    assign M_ARLEN   = len_q;
    assign M_ARSIZE  = 3'b010;
    assign M_ARBURST = 2'b01;
    assign rd_data   = M_RDATA;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;
    assign err       = err_q;

endmodule

// File: tb/tb_yolo_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_yolo_axi_rd_arbiter
//   Randomized bench for the AXI read arbiter. The bench plays the three
//   loaders and the AXI slave; expectations come from a round-robin model
//   (last served requester, sticky error flag) kept in plain integers.
// -----------------------------------------------------------------------------
module tb_yolo_axi_rd_arbiter;

    localparam int unsigned AD  = 32;
    localparam int unsigned DA  = 32;
    localparam int unsigned IDW = 4;
    localparam int unsigned NR  = 3;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AD-1:0]  req_addr;
    logic [NR*8-1:0]   req_len;
    logic [DA-1:0]     rd_data;
    logic [NR-1:0]     rd_valid;
    logic              rd_last;
    logic [NR-1:0]     rd_ready;
    logic              M_ARVALID, M_ARREADY;
    logic [AD-1:0]     M_ARADDR;
    logic [IDW-1:0]    M_ARID;
    logic [7:0]        M_ARLEN;
    logic [2:0]        M_ARSIZE;
    logic [1:0]        M_ARBURST;
    logic              M_RVALID, M_RREADY;
    logic [DA-1:0]     M_RDATA;
    logic              M_RLAST;
    logic [IDW-1:0]    M_RID;
    logic [1:0]        M_RRESP;
    logic              busy;
    logic [1:0]        grant_id;
    logic              err;

    always #5 clk = ~clk;

    yolo_axi_rd_arbiter #(
        .AXI_WIDTH_AD (AD),
        .AXI_WIDTH_DA (DA),
        .AXI_WIDTH_ID (IDW),
        .N_REQ        (NR)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .rd_ready  (rd_ready),
        .M_ARVALID (M_ARVALID),
        .M_ARREADY (M_ARREADY),
        .M_ARADDR  (M_ARADDR),
        .M_ARID    (M_ARID),
        .M_ARLEN   (M_ARLEN),
        .M_ARSIZE  (M_ARSIZE),
        .M_ARBURST (M_ARBURST),
        .M_RVALID  (M_RVALID),
        .M_RREADY  (M_RREADY),
        .M_RDATA   (M_RDATA),
        .M_RLAST   (M_RLAST),
        .M_RID     (M_RID),
        .M_RRESP   (M_RRESP),
        .busy      (busy),
        .grant_id  (grant_id),
        .err       (err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          mdl_last = 2;
    bit          mdl_err  = 1'b0;
    int          relen    = -1;
    logic [31:0] addr_a [NR];
    logic [7:0]  len_a  [NR];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First valid requester after the last one served, cyclically.
    function automatic int mdl_winner(input logic [2:0] m);
        for (int k = 1; k <= 3; k++) begin
            if (m[(mdl_last + k) % 3]) return (mdl_last + k) % 3;
        end
        return -1;
    endfunction

    task automatic set_reqs(input logic [2:0] m);
        req_valid = m;
        req_addr  = {addr_a[2], addr_a[1], addr_a[0]};
        req_len   = {len_a[2], len_a[1], len_a[0]};
    endtask

    task automatic rand_req(input int i);
        addr_a[i] = $urandom & 32'hFFFF_FFFC;
        len_a[i]  = (relen >= 0) ? 8'(relen) : 8'($urandom_range(15, 0));
    endtask

    // One arbitration + burst. Entered and left just after a rising edge.
    // err_mode: 0 clean, 1 RRESP on beat 0, 2 RLAST on beat 2, 3 bad RID,
    // 4 RLAST one beat late. abort_at >= 0 pulses rstn at that beat.
    task automatic do_burst(input logic [2:0] vmask, input int ar_wait, input int err_mode,
                            input int rbp_pct, input int abort_at);
        int          w, nb, beat, guard;
        logic [31:0] eaddr;
        logic [7:0]  elen;
        logic [2:0]  one_w, exp_rv, rr;
        bit          rv;

        set_reqs(vmask);
        rd_ready = 3'b111;
        @(negedge clk);
        check_eq("idle_busy", 64'(busy), 64'(0));
        check_eq("err", 64'(err), 64'(mdl_err));
        w = mdl_winner(vmask);
        if (w < 0) begin
            check_eq("idle_no_ready", 64'(req_ready), 64'(0));
            @(posedge clk); #1;
            return;
        end
        one_w = 3'b001 << w;
        check_eq("req_ready", 64'(req_ready), 64'(one_w));
        eaddr = addr_a[w];
        elen  = len_a[w];
        @(posedge clk); #1;

        // The accepted loader moves on to new values; AR fields must not follow.
        rand_req(w);
        set_reqs(vmask);
        M_ARREADY = (ar_wait == 0);
        for (int k = 0; k <= ar_wait; k++) begin
            @(negedge clk);
            check_eq("arvalid", 64'(M_ARVALID), 64'(1));
            check_eq("araddr", 64'(M_ARADDR), 64'(eaddr));
            check_eq("arlen", 64'(M_ARLEN), 64'(elen));
            check_eq("arid", 64'(M_ARID), 64'(w));
            check_eq("grant_id", 64'(grant_id), 64'(w));
            check_eq("busy_addr", 64'(busy), 64'(1));
            check_eq("ready_in_addr", 64'(req_ready), 64'(0));
            check_eq("rready_in_addr", 64'(M_RREADY), 64'(0));
            if (k == 0) begin
                check_eq("arsize", 64'(M_ARSIZE), 64'(3'b010));
                check_eq("arburst", 64'(M_ARBURST), 64'(2'b01));
            end
            @(posedge clk); #1;
            M_ARREADY = (k + 1 == ar_wait);
        end

        nb    = (err_mode == 2) ? 3 : (err_mode == 4) ? int'(elen) + 2 : int'(elen) + 1;
        beat  = 0;
        guard = 0;
        while (beat < nb && guard < 400) begin
            if (abort_at >= 0 && beat == abort_at) begin
                rd_ready = 3'b111;
                M_RVALID = 1'b1;
                rstn     = 1'b0;
                #1;
                check_eq("rst_rready", 64'(M_RREADY), 64'(0));
                check_eq("rst_arvalid", 64'(M_ARVALID), 64'(0));
                check_eq("rst_busy", 64'(busy), 64'(0));
                check_eq("rst_req_ready", 64'(req_ready), 64'(0));
                check_eq("rst_err", 64'(err), 64'(0));
                check_eq("rst_rd_valid", 64'(rd_valid), 64'(0));
                mdl_last = 2;
                mdl_err  = 1'b0;
                M_RVALID = 1'b0;
                M_RLAST  = 1'b0;
                @(posedge clk); #1;
                rstn = 1'b1;
                @(negedge clk);
                check_eq("ready_first_cycle", 64'(req_ready), 64'(0));
                @(posedge clk); #1;
                return;
            end
            rv       = ($urandom_range(99, 0) < 80);
            rr       = 3'($urandom);
            rr[w]    = ($urandom_range(99, 0) >= rbp_pct);
            rd_ready = rr;
            M_RVALID = rv;
            M_RDATA  = $urandom;
            M_RLAST  = (beat == nb - 1);
            M_RRESP  = (err_mode == 1 && beat == 0) ? 2'b10 : 2'b00;
            M_RID    = (err_mode == 3) ? IDW'(w + 4) : IDW'(w);
            exp_rv   = rv ? one_w : 3'b000;
            @(negedge clk);
            check_eq("rd_valid", 64'(rd_valid), 64'(exp_rv));
            check_eq("rready", 64'(M_RREADY), 64'(rr[w]));
            check_eq("rd_data", 64'(rd_data), 64'(M_RDATA));
            check_eq("rd_last", 64'(rd_last), 64'(M_RLAST));
            check_eq("busy_data", 64'(busy), 64'(1));
            check_eq("ready_in_data", 64'(req_ready), 64'(0));
            check_eq("arvalid_data", 64'(M_ARVALID), 64'(0));
            if (rv && rr[w]) beat++;
            @(posedge clk); #1;
            guard++;
        end
        check_eq("beats_done", 64'(beat), 64'(nb));
        M_RVALID = 1'b0;
        M_RLAST  = 1'b0;
        M_RRESP  = 2'b00;
        mdl_last = w;
        if (err_mode != 0) mdl_err = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        M_ARREADY = 1'b0;
        M_RVALID  = 1'b0;
        M_RDATA   = '0;
        M_RLAST   = 1'b0;
        M_RID     = '0;
        M_RRESP   = 2'b00;
        rd_ready  = 3'b111;
        for (int i = 0; i < 3; i++) rand_req(i);
        set_reqs(3'b111);

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset_req_ready", 64'(req_ready), 64'(0));
        check_eq("reset_busy", 64'(busy), 64'(0));
        check_eq("reset_arvalid", 64'(M_ARVALID), 64'(0));
        check_eq("reset_rready", 64'(M_RREADY), 64'(0));
        check_eq("reset_rd_valid", 64'(rd_valid), 64'(0));
        check_eq("reset_grant_id", 64'(grant_id), 64'(0));
        check_eq("reset_arid", 64'(M_ARID), 64'(0));
        check_eq("reset_araddr", 64'(M_ARADDR), 64'(0));
        check_eq("reset_err", 64'(err), 64'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check_eq("ready_first_cycle", 64'(req_ready), 64'(0));
        @(posedge clk); #1;

        // All three held valid, len=3: grants rotate 0,1,2,0,1,2.
        relen = 3;
        for (int i = 0; i < 3; i++) rand_req(i);
        for (int b = 0; b < 6; b++) do_burst(3'b111, $urandom_range(2, 0), 0, 0, -1);

        // Single request from loader 1.
        addr_a[1] = 32'h0000_1000;
        len_a[1]  = 8'd7;
        do_burst(3'b010, 0, 0, 0, -1);

        // AR backpressure for 5 cycles.
        do_burst(3'b001, 5, 0, 0, -1);

        // Loader 2 throttles its beats on a len=5 burst.
        len_a[2] = 8'd5;
        do_burst(3'b100, 0, 0, 50, -1);

        // Random request masks, lengths and backpressure.
        relen = -1;
        for (int b = 0; b < 30; b++) begin
            do_burst(3'($urandom), $urandom_range(3, 0), 0, $urandom_range(40, 0), -1);
        end

        // Error bursts; err must stick across later clean bursts.
        do_burst(3'b111, 0, 1, 0, -1);
        for (int i = 0; i < 3; i++) len_a[i] = 8'd3;
        do_burst(3'b111, 0, 2, 0, -1);
        do_burst(3'b111, 1, 3, 20, -1);
        do_burst(3'b111, 0, 4, 0, -1);
        do_burst(3'b011, 0, 0, 0, -1);

        // Reset during DATA at beat 3; loader 0 must win afterwards.
        relen = 7;
        for (int i = 0; i < 3; i++) rand_req(i);
        do_burst(3'b111, 0, 0, 0, 3);
        do_burst(3'b111, 0, 0, 0, -1);
        do_burst(3'b000, 0, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
